// File: rtl/multicycle_decoder.sv
// Main control unit for the multicycle ARM core: instruction decode plus the
// Moore FSM that sequences fetch, decode, execute and writeback.
module multicycle_decoder #(
  parameter int STATE_W = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  output logic       PCS,
  output logic       NextPC,
  output logic       RegW,
  output logic       MemW,
  output logic [1:0] FlagW,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic [1:0] ResultSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUControl,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc
);

  typedef enum logic [STATE_W-1:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECUTER, EXECUTEI, ALUWB, BRANCH, UNKNOWN
  } state_t;

  state_t state;

  // NOTE: state is updated with non-blocking assignments only; the default arm
  // also recovers any unused encoding back to FETCH.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= FETCH;
    end else begin
      case (state)
        FETCH:    state <= DECODE;
        DECODE: begin
          case (Op)
            2'b00:   state <= Funct[5] ? EXECUTEI : EXECUTER;
            2'b01:   state <= MEMADR;
            2'b10:   state <= BRANCH;
            default: state <= UNKNOWN;
          endcase
        end
        MEMADR:   state <= Funct[0] ? MEMREAD : MEMWRITE;
        MEMREAD:  state <= MEMWB;
        EXECUTER: state <= ALUWB;
        EXECUTEI: state <= ALUWB;
        default:  state <= FETCH;
      endcase
    end
  end

  logic       irwrite_s, nextpc_s, regw_s, memw_s, branch, alu_op;
  logic [1:0] flagw_s;

  // NOTE: every signal gets a default at the top so no latch is inferred.
  always_comb begin
    irwrite_s = 1'b0;
    nextpc_s  = 1'b0;
    regw_s    = 1'b0;
    memw_s    = 1'b0;
    branch    = 1'b0;
    alu_op    = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    case (state)
      FETCH: begin
        irwrite_s = 1'b1;
        nextpc_s  = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      MEMADR:   ALUSrcB = 2'b01;
      MEMREAD:  AdrSrc  = 1'b1;
      MEMWB: begin
        ResultSrc = 2'b01;
        regw_s    = 1'b1;
      end
      MEMWRITE: begin
        AdrSrc = 1'b1;
        memw_s = 1'b1;
      end
      EXECUTER: alu_op = 1'b1;
      EXECUTEI: begin
        ALUSrcB = 2'b01;
        alu_op  = 1'b1;
      end
      ALUWB:    regw_s = 1'b1;
      BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        branch    = 1'b1;
      end
      default: ;
    endcase
  end

  // ALU decode: only ADD/SUB update C,V; an unsupported cmd leaves flags alone.
  always_comb begin
    ALUControl = 2'b00;
    flagw_s    = 2'b00;
    if (alu_op) begin
      case (Funct[4:1])
        4'b0100: begin ALUControl = 2'b00; flagw_s = {Funct[0], Funct[0]}; end
        4'b0010: begin ALUControl = 2'b01; flagw_s = {Funct[0], Funct[0]}; end
        4'b0000: begin ALUControl = 2'b10; flagw_s = {Funct[0], 1'b0};     end
        4'b1100: begin ALUControl = 2'b11; flagw_s = {Funct[0], 1'b0};     end
        default: ;
      endcase
    end
  end

  // Enables drop the moment reset asserts so an aborted instruction never writes.
  assign IRWrite = irwrite_s & reset_n;
  assign NextPC  = nextpc_s & reset_n;
  assign RegW    = regw_s & reset_n;
  assign MemW    = memw_s & reset_n;
  assign FlagW   = flagw_s & {2{reset_n}};
  assign PCS     = reset_n & ((regw_s & (Rd == 4'hF)) | branch);

  assign ImmSrc  = Op;
  assign RegSrc  = {Op == 2'b01, Op == 2'b10};

endmodule

// File: tb/tb_multicycle_decoder.sv
// Random-instruction bench for multicycle_decoder; expected per-cycle control
// words come from an instruction-level model of each instruction class.
module tb_multicycle_decoder;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic       PCS, NextPC, RegW, MemW, IRWrite, AdrSrc, ALUSrcA;
  logic [1:0] FlagW, ResultSrc, ALUSrcB, ALUControl, ImmSrc, RegSrc;

  multicycle_decoder dut (
    .clk(clk), .reset_n(reset_n), .Op(Op), .Funct(Funct), .Rd(Rd),
    .PCS(PCS), .NextPC(NextPC), .RegW(RegW), .MemW(MemW), .FlagW(FlagW),
    .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
    .ImmSrc(ImmSrc), .RegSrc(RegSrc)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pcs;
    logic       nextpc;
    logic       regw;
    logic       memw;
    logic [1:0] flagw;
    logic       irwrite;
    logic       adrsrc;
    logic [1:0] resultsrc;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] alucontrol;
    logic [1:0] immsrc;
    logic [1:0] regsrc;
  } ctl_t;

  ctl_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %05h expected %05h", tag, obs, exp);
    end
  endtask

  function automatic ctl_t observed();
    return {PCS, NextPC, RegW, MemW, FlagW, IRWrite, AdrSrc, ResultSrc,
            ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc};
  endfunction

  function automatic ctl_t blank(input logic [1:0] op);
    ctl_t c = '0;
    c.immsrc = op;
    c.regsrc = {op == 2'b01, op == 2'b10};
    return c;
  endfunction

  // Datapath selects while fetching/decoding: PC + 4 routed to the result bus.
  function automatic ctl_t pc_plus4(input logic [1:0] op);
    ctl_t c = blank(op);
    c.alusrca   = 1'b1;
    c.alusrcb   = 2'b10;
    c.resultsrc = 2'b10;
    return c;
  endfunction

  // Builds the whole cycle-by-cycle control trace of one instruction.
  task automatic build(input logic [1:0] op, input logic [5:0] funct, input logic [3:0] rd);
    ctl_t c;
    logic [3:0] cmd;
    exp_q.delete();
    c = pc_plus4(op); c.irwrite = 1'b1; c.nextpc = 1'b1;
    exp_q.push_back(c);
    exp_q.push_back(pc_plus4(op));
    case (op)
      2'b00: begin
        c = blank(op);
        c.alusrcb = funct[5] ? 2'b01 : 2'b00;
        cmd = funct[4:1];
        if (cmd == 4'd4)       begin c.alucontrol = 2'd0; c.flagw = {2{funct[0]}}; end
        else if (cmd == 4'd2)  begin c.alucontrol = 2'd1; c.flagw = {2{funct[0]}}; end
        else if (cmd == 4'd0)  begin c.alucontrol = 2'd2; c.flagw = {funct[0], 1'b0}; end
        else if (cmd == 4'd12) begin c.alucontrol = 2'd3; c.flagw = {funct[0], 1'b0}; end
        exp_q.push_back(c);
        c = blank(op); c.regw = 1'b1; c.pcs = (rd == 4'd15);
        exp_q.push_back(c);
      end
      2'b01: begin
        c = blank(op); c.alusrcb = 2'b01;
        exp_q.push_back(c);
        c = blank(op); c.adrsrc = 1'b1;
        if (funct[0]) begin
          exp_q.push_back(c);
          c = blank(op); c.resultsrc = 2'b01; c.regw = 1'b1; c.pcs = (rd == 4'd15);
          exp_q.push_back(c);
        end else begin
          c.memw = 1'b1;
          exp_q.push_back(c);
        end
      end
      2'b10: begin
        c = blank(op); c.alusrcb = 2'b01; c.resultsrc = 2'b10; c.pcs = 1'b1;
        exp_q.push_back(c);
      end
      default: exp_q.push_back(blank(op));
    endcase
  endtask

  // Entered 1 time unit after the edge that put the FSM in FETCH.
  task automatic run_instr(input logic [1:0] op, input logic [5:0] funct, input logic [3:0] rd,
                           input string name);
    Op = op; Funct = funct; Rd = rd;
    build(op, funct, rd);
    foreach (exp_q[i]) begin
      @(negedge clk);
      check($sformatf("%s step%0d", name, i), 32'(observed()), 32'(exp_q[i]));
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_reset_state(input string name);
    check(name, 32'(observed()), 32'(pc_plus4(Op)));
  endtask

  // STR aborted by reset while in MEMWRITE, then a clean restart at FETCH.
  task automatic run_abort(input logic [3:0] rd);
    Op = 2'b01; Funct = 6'b011000; Rd = rd;
    build(Op, Funct, Rd);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("abort step%0d", i), 32'(observed()), 32'(exp_q[i]));
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    check("abort memwrite", 32'(observed()), 32'(exp_q[3]));
    #1 reset_n = 1'b0;
    #1 check_reset_state("abort async drop");
    @(posedge clk);
    @(negedge clk);
    check_reset_state("abort held");
    @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  function automatic logic [5:0] rand_funct(input logic [1:0] op);
    logic [3:0] cmd;
    logic [3:0] legal[4];
    legal[0] = 4'd4; legal[1] = 4'd2; legal[2] = 4'd0; legal[3] = 4'd12;
    if (op != 2'b00) return 6'($urandom);
    cmd = ($urandom_range(0, 4) == 0) ? 4'($urandom) : legal[$urandom_range(0, 3)];
    return {1'($urandom), cmd, 1'($urandom)};
  endfunction

  initial begin
    logic [1:0] op;
    logic [3:0] rd;
    reset_n = 1'b0;
    Op = 2'b00; Funct = 6'b001001; Rd = 4'd3;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_state("reset hold");
    Op = 2'b10;
    #1 check_reset_state("reset hold op10");
    Op = 2'b00;
    @(posedge clk);
    #1 reset_n = 1'b1;

    run_instr(2'b00, 6'b001001, 4'd3,  "adds_reg");
    run_instr(2'b00, 6'b100001, 4'd4,  "ands_imm");
    run_instr(2'b01, 6'b011001, 4'd5,  "ldr");
    run_instr(2'b01, 6'b011000, 4'd6,  "str");
    run_instr(2'b10, 6'b101000, 4'd0,  "branch");
    run_instr(2'b01, 6'b011001, 4'd15, "ldr_pc");
    run_instr(2'b00, 6'b001000, 4'd15, "add_pc");
    run_instr(2'b00, 6'b000101, 4'd1,  "subs_reg");
    run_instr(2'b00, 6'b011001, 4'd2,  "orrs_reg");
    run_instr(2'b00, 6'b010111, 4'd2,  "bad_cmd");
    run_instr(2'b11, 6'b111111, 4'd15, "undef");
    run_abort(4'd7);
    run_instr(2'b00, 6'b101001, 4'd8,  "after_abort");

    for (int n = 0; n < 150; n++) begin
      op = 2'($urandom);
      rd = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom);
      run_instr(op, rand_funct(op), rd, $sformatf("rand%0d", n));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
